parity_stream_codec: RTL

- Parametrised, streaming successor to the 8-bit parity generator/checker.
- Accepts DATA_W-bit words over a valid/ready handshake.
- Per word, either generates an odd/even parity bit (GEN) or checks a supplied parity bit (CHK).
- Returns the word plus parity through a one-entry registered output stage; keeps a sticky error flag and a saturating error counter for the downstream status register.

---
 rtl/parity_pkg.sv | 23 ++
 rtl/parity_tree.sv | 18 +
 rtl/parity_stream_codec.sv | 130 +++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared constants and helpers for the parity stream codec.
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam logic OP_GEN   = 1'b0;
  localparam logic OP_CHK   = 1'b1;

  // Output register occupancy
  typedef enum logic {
    StEmpty,
    StFull
  } out_state_e;

  // Saturating increment on counters of up to 32 bits; callers cast to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    if (val >= max_val) begin
      return max_val;
    end
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational parity reduction of a word with odd/even select.
// Returns the bit that makes {i_data, bit} carry the selected parity.
module parity_tree
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_odd,
  output logic              o_parity
);

  logic w_red;

  assign w_red    = ^i_data;
  assign o_parity = (i_odd == PAR_EVEN) ? w_red : ~w_red;

endmodule

// File: rtl/parity_stream_codec.sv
// Streaming parity generator/checker with a one-entry registered output stage,
// sticky error flag and saturating error counter.
// Optional macro PARITY_ERR_INJECT_EN adds inject_err, which inverts the generated
// parity bit of GEN words for downstream self-test.
// CNT_W is limited to 32 bits by the shared saturating-increment helper.
module parity_stream_codec
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PARITY_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  input  logic              in_odd,
  input  logic              in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  out_state_e r_state_q, r_state_d;
  logic [DATA_W:0]  r_data_q;
  logic             r_err_q;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic             r_sticky_q, r_sticky_d;

  logic w_in_hs, w_out_hs;
  logic w_is_chk, w_odd_sel, w_tree, w_inject, w_par, w_chk_err;

  assign w_is_chk  = (in_chk == OP_CHK);
  assign out_valid = (r_state_q == StFull);
  assign in_ready  = ~out_valid | out_ready;
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;

`ifdef PARITY_ERR_INJECT_EN
  assign w_inject = inject_err;
`else
  assign w_inject = 1'b0;
`endif

  // Folding the received parity into the odd/even select lets one tree serve both
  // modes: in GEN it yields the parity bit, in CHK it yields the error flag.
  assign w_odd_sel = (in_odd == PAR_ODD) ^ (w_is_chk & in_parity);

  parity_tree #(
    .DATA_W (DATA_W)
  ) u_tree (
    .i_data   (in_data),
    .i_odd    (w_odd_sel),
    .o_parity (w_tree)
  );

  assign w_chk_err = w_is_chk & w_tree;
  assign w_par     = (in_chk == OP_GEN) ? (w_tree ^ w_inject) : in_parity;

  // Output stage occupancy: fill on accept, drain only when nothing replaces the word
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      StEmpty: if (w_in_hs) r_state_d = StFull;
      StFull:  if (w_out_hs && !w_in_hs) r_state_d = StEmpty;
      default: r_state_d = StEmpty;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= StEmpty;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  // Output payload loads on every accepted word and holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
      r_err_q  <= 1'b0;
    end else if (w_in_hs) begin
      r_data_q <= {in_data, w_par};
      r_err_q  <= w_chk_err;
    end
  end

  // Error bookkeeping: clear is applied before counting a coincident error
  always_comb begin
    r_cnt_d    = r_cnt_q;
    r_sticky_d = r_sticky_q;
    if (clr_err) begin
      r_cnt_d    = '0;
      r_sticky_d = 1'b0;
    end
    if (w_in_hs && w_chk_err) begin
      r_cnt_d    = CNT_W'(sat_inc(32'(r_cnt_d), 32'(CNT_MAX)));
      r_sticky_d = 1'b1;
    end
  end

  // Error status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_q    <= '0;
      r_sticky_q <= 1'b0;
    end else begin
      r_cnt_q    <= r_cnt_d;
      r_sticky_q <= r_sticky_d;
    end
  end

  assign out_data   = r_data_q;
  assign out_err    = r_err_q;
  assign err_sticky = r_sticky_q;
  assign err_count  = r_cnt_q;

endmodule
